// File: rtl/fp_minmax_reduce.sv
// Streaming FMIN/FMAX reduction: folds a vector of floats into one accumulator
// through a single min_max stage, with sticky exception flags.

module min_max #(
  parameter int unsigned exp_width  = 8,
  parameter int unsigned mant_width = 24
) (
  input  logic [exp_width+mant_width-1:0] a,
  input  logic [exp_width+mant_width-1:0] b,
  input  logic                            op,
  output logic [exp_width+mant_width-1:0] out,
  output logic [4:0]                      exceptions
);
  localparam int unsigned W  = exp_width + mant_width;
  localparam int unsigned FW = mant_width - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {exp_width{1'b1}}, 1'b1, {(FW-1){1'b0}}};

  logic w_a_sign, w_b_sign, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic w_a_lt_b, w_b_lt_a;
  logic [W-2:0] w_a_mag, w_b_mag;

  assign w_a_sign = a[W-1];
  assign w_b_sign = b[W-1];
  assign w_a_mag  = a[W-2:0];
  assign w_b_mag  = b[W-2:0];
  assign w_a_nan  = (&a[W-2 -: exp_width]) && (|a[FW-1:0]);
  assign w_b_nan  = (&b[W-2 -: exp_width]) && (|b[FW-1:0]);
  assign w_a_snan = w_a_nan && !a[FW-1];
  assign w_b_snan = w_b_nan && !b[FW-1];

  // Sign-magnitude ordering; -0 sorts below +0 so signed zeros resolve by sign.
  assign w_a_lt_b = (w_a_sign != w_b_sign) ? w_a_sign :
                    (w_a_sign ? (w_a_mag > w_b_mag) : (w_a_mag < w_b_mag));
  assign w_b_lt_a = (w_a_sign != w_b_sign) ? w_b_sign :
                    (w_b_sign ? (w_b_mag > w_a_mag) : (w_b_mag < w_a_mag));

  always_comb begin
    out        = a;
    exceptions = {(w_a_snan || w_b_snan), 4'b0000};
    if (w_a_nan && w_b_nan) out = QNAN;
    else if (w_a_nan)       out = b;
    else if (w_b_nan)       out = a;
    else if (op)            out = w_a_lt_b ? b : a;
    else                    out = w_b_lt_a ? b : a;
  end
endmodule

module fp_minmax_reduce #(
  parameter int unsigned exp_width  = 8,
  parameter int unsigned mant_width = 24,
  parameter int unsigned cnt_width  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            op,
  input  logic [cnt_width-1:0]            len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [exp_width+mant_width-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [exp_width+mant_width-1:0] out_data,
  output logic [4:0]                      exceptions,
  output logic                            busy
);
  localparam int unsigned W  = exp_width + mant_width;
  localparam int unsigned FW = mant_width - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {exp_width{1'b1}}, 1'b1, {(FW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t               r_state, w_next;
  logic                 r_op;
  logic [cnt_width-1:0] r_remaining;
  logic [W-1:0]         r_acc;
  logic [4:0]           r_flags;
  logic [W-1:0]         w_mm_out;
  logic [4:0]           w_mm_exc;
  logic                 w_fire;

  min_max #(
    .exp_width (exp_width),
    .mant_width(mant_width)
  ) u_min_max (
    .a         (r_acc),
    .b         (in_data),
    .op        (r_op),
    .out       (w_mm_out),
    .exceptions(w_mm_exc)
  );

  assign w_fire = in_valid && (r_state == S_ACCUM);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len != '0) ? S_ACCUM : S_DONE;
      S_ACCUM: if (w_fire && r_remaining == cnt_width'(1)) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == S_ACCUM);
    out_valid  = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
    out_data   = r_acc;
    exceptions = r_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= 1'b0;
      r_remaining <= '0;
      r_acc       <= '0;
      r_flags     <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_op        <= op;
      r_remaining <= len;
      r_acc       <= QNAN;
      r_flags     <= '0;
    end else if (w_fire) begin
      r_acc       <= w_mm_out;
      r_flags     <= r_flags | w_mm_exc;
      r_remaining <= r_remaining - 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed vector bench for fp_minmax_reduce: latency, result, flags, stalls,
// backpressure, ignored start pulses and mid-operation reset.

module tb_fp_minmax_reduce;
  logic        clk = 1'b0;
  logic        rst, start, op, in_valid, out_ready;
  logic [7:0]  len;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;
  logic [4:0]  exceptions;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_minmax_reduce #(.exp_width(8), .mant_width(24), .cnt_width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .exceptions(exceptions), .busy(busy)
  );

  typedef struct packed {
    logic             op;
    logic [7:0]       len;
    logic [4:0][31:0] el;
    logic [31:0]      exp_d;
    logic [4:0]       exp_x;
    logic             stall;
    logic [7:0]       hold;
    logic             glitch;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic o, input logic [7:0] n,
                              input logic [31:0] e0, e1, e2, e3, e4,
                              input logic [31:0] d, input logic [4:0] x,
                              input logic s, input logic [7:0] h, input logic g);
    vec_t v;
    v.op = o; v.len = n;
    v.el[0] = e0; v.el[1] = e1; v.el[2] = e2; v.el[3] = e3; v.el[4] = e4;
    v.exp_d = d; v.exp_x = x; v.stall = s; v.hold = h; v.glitch = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run(input int id, input vec_t v);
    int idx = 0, stalls = 0, ovc = 0;
    logic accum_ok = 1'b1, stable = 1'b1;
    @(negedge clk);
    start = 1'b1; op = v.op; len = v.len;
    @(negedge clk);
    start = 1'b0; op = ~v.op; len = 8'hff;
    for (int c = 1; c < 60; c++) begin
      if (c > 1) @(negedge clk);
      if (out_valid) begin ovc = c; break; end
      if (!in_ready || !busy) accum_ok = 1'b0;
      start = v.glitch && (c == 2);
      if (idx >= int'(v.len)) in_valid = 1'b0;
      else if (v.stall && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0; stalls++;
      end else begin
        in_valid = 1'b1; in_data = v.el[idx]; idx++;
      end
    end
    in_valid = 1'b0; start = 1'b0;
    chk($sformatf("v%0d latency", id), ovc, int'(v.len) + 1 + stalls);
    chk($sformatf("v%0d in_ready_accum", id), {31'b0, accum_ok}, 32'd1);
    chk($sformatf("v%0d in_ready_done", id), {31'b0, in_ready}, 32'd0);
    chk($sformatf("v%0d data", id), out_data, v.exp_d);
    chk($sformatf("v%0d exc", id), {27'b0, exceptions}, {27'b0, v.exp_x});
    for (int h = 0; h < int'(v.hold); h++) begin
      start = v.glitch;
      @(negedge clk);
      if (!out_valid || out_data !== v.exp_d || exceptions !== v.exp_x) stable = 1'b0;
    end
    start = 1'b0;
    if (v.hold != 0) chk($sformatf("v%0d hold_stable", id), {31'b0, stable}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d idle_after", id), {29'b0, busy, out_valid, in_ready}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 8'd3, 32'h3f800000, 32'hc0000000, 32'h40400000, 0, 0, 32'hc0000000, 5'b0, 1'b0, 8'd10, 1'b0);
    vecs[1]  = mk(1'b1, 8'd2, 32'h80000000, 32'h00000000, 0, 0, 0, 32'h00000000, 5'b0, 1'b0, 8'd0, 1'b0);
    vecs[2]  = mk(1'b0, 8'd2, 32'h00000000, 32'h80000000, 0, 0, 0, 32'h80000000, 5'b0, 1'b0, 8'd0, 1'b0);
    vecs[3]  = mk(1'b1, 8'd2, 32'h00000000, 32'h80000000, 0, 0, 0, 32'h00000000, 5'b0, 1'b0, 8'd0, 1'b0);
    vecs[4]  = mk(1'b0, 8'd2, 32'h80000000, 32'h00000000, 0, 0, 0, 32'h80000000, 5'b0, 1'b0, 8'd0, 1'b0);
    vecs[5]  = mk(1'b1, 8'd2, 32'h7fc00000, 32'h40400000, 0, 0, 0, 32'h40400000, 5'b0, 1'b0, 8'd0, 1'b0);
    vecs[6]  = mk(1'b0, 8'd2, 32'h7f800001, 32'h3f800000, 0, 0, 0, 32'h3f800000, 5'b10000, 1'b0, 8'd0, 1'b0);
    vecs[7]  = mk(1'b1, 8'd3, 32'h7fc00000, 32'h7fc00000, 32'h7fc00000, 0, 0, 32'h7fc00000, 5'b0, 1'b0, 8'd0, 1'b0);
    vecs[8]  = mk(1'b1, 8'd0, 0, 0, 0, 0, 0, 32'h7fc00000, 5'b0, 1'b0, 8'd0, 1'b0);
    vecs[9]  = mk(1'b0, 8'd4, 32'h3f800000, 32'h40400000, 32'hc0a00000, 32'h40000000, 0, 32'hc0a00000, 5'b0, 1'b0, 8'd3, 1'b1);
    vecs[10] = mk(1'b1, 8'd5, 32'h3f800000, 32'hbf800000, 32'h40a00000, 32'h7f800001, 32'h7fc00000, 32'h40a00000, 5'b10000, 1'b1, 8'd0, 1'b0);

    rst = 1'b1; start = 1'b0; op = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {29'b0, busy, out_valid, in_ready}, 32'd0);
    chk("reset_data", out_data, 32'h0);
    chk("reset_exc", {27'b0, exceptions}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run(i, vecs[i]);

    // Reset after two of four elements: partial result must vanish.
    @(negedge clk);
    start = 1'b1; op = 1'b0; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = (k == 0) ? 32'hc1000000 : 32'h7f800001;
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctrl", {29'b0, busy, out_valid, in_ready}, 32'd0);
    chk("midrst_data", out_data, 32'h0);
    chk("midrst_exc", {27'b0, exceptions}, 32'd0);
    run(11, mk(1'b0, 8'd1, 32'h41200000, 0, 0, 0, 0, 32'h41200000, 5'b0, 1'b0, 8'd0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
